complex_mac_pipe: RTL and testbench

Parametrised, fully pipelined complex multiply / multiply-accumulate unit with valid/ready flow control, selectable conjugation, round-half-up rescaling and output saturation. It is the next-generation arithmetic core for gate application and state-vector inner products. It sits between the amplitude fetch logic (upstream) and the state-vector write-back or reduction logic (downstream), and replaces fixed-width, handshake-less multiplication.

---
 rtl/complex_mac_pipe.sv | 232 +++++++++++++++++++++++
 tb/tb_complex_mac_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/complex_mac_pipe.sv
// Pipelined complex multiply / multiply-accumulate unit with valid/ready flow control,
// optional conjugation of b, round-half-up rescaling and output saturation.
module complex_mac_pipe #(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned FRAC_W  = 15,
    parameter int unsigned GUARD_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_a_re,
    input  logic signed [DATA_W-1:0] in_a_im,
    input  logic signed [DATA_W-1:0] in_b_re,
    input  logic signed [DATA_W-1:0] in_b_im,
    input  logic        [1:0]        in_mode,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_re,
    output logic signed [DATA_W-1:0] out_im,
    output logic                     out_sat
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = PROD_W + 1;
    localparam int unsigned ACC_W  = SUM_W + GUARD_W;
    localparam int unsigned EXT_W  = ACC_W + 1;

    // Rounding increment and saturation bounds, evaluated one bit wider than the accumulator
    localparam logic signed [EXT_W-1:0] RND_INC = EXT_W'(1) << (FRAC_W - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (DATA_W - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'd0,
        MODE_CMUL = 2'd1,
        MODE_MAC  = 2'd2,
        MODE_CMAC = 2'd3
    } mode_e;

    // Round half up, shift down to the operand Q format, clip; returns {clip, value}
    function automatic logic [DATA_W:0] rescale(input logic signed [ACC_W-1:0] x);
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] shf;
        logic                    clip;
        logic        [DATA_W-1:0] val;
        rnd  = EXT_W'(x) + RND_INC;
        shf  = rnd >>> FRAC_W;
        clip = 1'b0;
        val  = shf[DATA_W-1:0];
        if (shf > SAT_MAX) begin
            clip = 1'b1;
            val  = SAT_MAX[DATA_W-1:0];
        end else if (shf < SAT_MIN) begin
            clip = 1'b1;
            val  = SAT_MIN[DATA_W-1:0];
        end
        return {clip, val};
    endfunction

    logic adv;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_a_re_q, s1_a_re_d;
    logic signed [DATA_W-1:0] s1_a_im_q, s1_a_im_d;
    logic signed [DATA_W-1:0] s1_b_re_q, s1_b_re_d;
    logic signed [DATA_W-1:0] s1_b_im_q, s1_b_im_d;
    mode_e                    s1_mode_q, s1_mode_d;
    logic                     s1_last_q, s1_last_d;

    logic                     s2_valid_q, s2_valid_d;
    logic signed [PROD_W-1:0] s2_ac_q, s2_ac_d;
    logic signed [PROD_W-1:0] s2_bd_q, s2_bd_d;
    logic signed [PROD_W-1:0] s2_ad_q, s2_ad_d;
    logic signed [PROD_W-1:0] s2_bc_q, s2_bc_d;
    mode_e                    s2_mode_q, s2_mode_d;
    logic                     s2_last_q, s2_last_d;

    logic signed [ACC_W-1:0]  acc_re_q, acc_re_d;
    logic signed [ACC_W-1:0]  acc_im_q, acc_im_d;

    logic                     out_valid_q, out_valid_d;
    logic signed [DATA_W-1:0] out_re_q, out_re_d;
    logic signed [DATA_W-1:0] out_im_q, out_im_d;
    logic                     out_sat_q, out_sat_d;

    logic signed [SUM_W-1:0]  sum_re, sum_im;
    logic signed [ACC_W-1:0]  tot_re, tot_im;
    logic        [DATA_W:0]   res_re, res_im;
    logic                     s2_conj, s2_accum;

    // One global advance: the whole pipe moves unless a result is held for downstream
    assign adv      = !out_valid_q || out_ready;
    assign in_ready = adv && !rst;

    assign s2_conj  = s2_mode_q[0];
    assign s2_accum = s2_mode_q[1];

    // S1 capture and S2 products
    always_comb begin
        s1_valid_d = in_valid;
        s1_a_re_d  = s1_a_re_q;
        s1_a_im_d  = s1_a_im_q;
        s1_b_re_d  = s1_b_re_q;
        s1_b_im_d  = s1_b_im_q;
        s1_mode_d  = s1_mode_q;
        s1_last_d  = s1_last_q;
        if (in_valid) begin
            s1_a_re_d = in_a_re;
            s1_a_im_d = in_a_im;
            s1_b_re_d = in_b_re;
            s1_b_im_d = in_b_im;
            s1_mode_d = mode_e'(in_mode);
            s1_last_d = in_last;
        end

        s2_valid_d = s1_valid_q;
        s2_ac_d    = s2_ac_q;
        s2_bd_d    = s2_bd_q;
        s2_ad_d    = s2_ad_q;
        s2_bc_d    = s2_bc_q;
        s2_mode_d  = s2_mode_q;
        s2_last_d  = s2_last_q;
        if (s1_valid_q) begin
            s2_ac_d   = PROD_W'(s1_a_re_q) * PROD_W'(s1_b_re_q);
            s2_bd_d   = PROD_W'(s1_a_im_q) * PROD_W'(s1_b_im_q);
            s2_ad_d   = PROD_W'(s1_a_re_q) * PROD_W'(s1_b_im_q);
            s2_bc_d   = PROD_W'(s1_a_im_q) * PROD_W'(s1_b_re_q);
            s2_mode_d = s1_mode_q;
            s2_last_d = s1_last_q;
        end
    end

    // S3 combine, accumulate, rescale into the output register
    always_comb begin
        sum_re = '0;
        sum_im = '0;
        if (s2_conj) begin
            sum_re = SUM_W'(s2_ac_q) + SUM_W'(s2_bd_q);
            sum_im = SUM_W'(s2_bc_q) - SUM_W'(s2_ad_q);
        end else begin
            sum_re = SUM_W'(s2_ac_q) - SUM_W'(s2_bd_q);
            sum_im = SUM_W'(s2_ad_q) + SUM_W'(s2_bc_q);
        end

        tot_re = ACC_W'(sum_re);
        tot_im = ACC_W'(sum_im);
        if (s2_accum) begin
            tot_re = acc_re_q + ACC_W'(sum_re);
            tot_im = acc_im_q + ACC_W'(sum_im);
        end

        res_re = rescale(tot_re);
        res_im = rescale(tot_im);

        acc_re_d    = acc_re_q;
        acc_im_d    = acc_im_q;
        out_valid_d = 1'b0;
        out_re_d    = out_re_q;
        out_im_d    = out_im_q;
        out_sat_d   = out_sat_q;

        if (s2_valid_q) begin
            if (s2_accum && !s2_last_q) begin
                acc_re_d = tot_re;
                acc_im_d = tot_im;
            end else begin
                out_valid_d = 1'b1;
                out_re_d    = res_re[DATA_W-1:0];
                out_im_d    = res_im[DATA_W-1:0];
                out_sat_d   = res_re[DATA_W] | res_im[DATA_W];
                if (s2_accum) begin
                    acc_re_d = '0;
                    acc_im_d = '0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_re_q   <= '0;
            s1_a_im_q   <= '0;
            s1_b_re_q   <= '0;
            s1_b_im_q   <= '0;
            s1_mode_q   <= MODE_MUL;
            s1_last_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_ac_q     <= '0;
            s2_bd_q     <= '0;
            s2_ad_q     <= '0;
            s2_bc_q     <= '0;
            s2_mode_q   <= MODE_MUL;
            s2_last_q   <= 1'b0;
            acc_re_q    <= '0;
            acc_im_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_sat_q   <= 1'b0;
        end else if (adv) begin
            s1_valid_q  <= s1_valid_d;
            s1_a_re_q   <= s1_a_re_d;
            s1_a_im_q   <= s1_a_im_d;
            s1_b_re_q   <= s1_b_re_d;
            s1_b_im_q   <= s1_b_im_d;
            s1_mode_q   <= s1_mode_d;
            s1_last_q   <= s1_last_d;
            s2_valid_q  <= s2_valid_d;
            s2_ac_q     <= s2_ac_d;
            s2_bd_q     <= s2_bd_d;
            s2_ad_q     <= s2_ad_d;
            s2_bc_q     <= s2_bc_d;
            s2_mode_q   <= s2_mode_d;
            s2_last_q   <= s2_last_d;
            acc_re_q    <= acc_re_d;
            acc_im_q    <= acc_im_d;
            out_valid_q <= out_valid_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_complex_mac_pipe.sv
// Directed bench for complex_mac_pipe: latency, rounding, conjugation, saturation,
// accumulation, backpressure and reset mid-accumulation, at default parameters.
module tb_complex_mac_pipe;

    localparam int unsigned DW = 16;
    localparam logic [1:0] M_MUL  = 2'd0;
    localparam logic [1:0] M_CMUL = 2'd1;
    localparam logic [1:0] M_MAC  = 2'd2;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, in_last, out_valid, out_ready, out_sat;
    logic [DW-1:0] in_a_re, in_a_im, in_b_re, in_b_im, out_re, out_im;
    logic [1:0]    in_mode;
    int            total = 0;
    int            bad = 0;
    logic [2*DW:0] rx[$];

    always #5 clk = ~clk;

    complex_mac_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a_re  (in_a_re),
        .in_a_im  (in_a_im),
        .in_b_re  (in_b_re),
        .in_b_im  (in_b_im),
        .in_mode  (in_mode),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_sat  (out_sat)
    );

    // Results handed to downstream, recorded half a cycle before the accepting edge
    always @(negedge clk)
        if (!rst && out_valid && out_ready) rx.push_back({out_sat, out_re, out_im});

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag, input int idx, input logic [2*DW:0] exp);
        logic [2*DW:0] obs;
        obs = (idx < rx.size()) ? rx[idx] : 'x;
        check(tag, 64'(obs), 64'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] a_re, input logic [DW-1:0] a_im,
                        input logic [DW-1:0] b_re, input logic [DW-1:0] b_im,
                        input logic [1:0] mode, input logic last);
        int n;
        in_a_re  = a_re;
        in_a_im  = a_im;
        in_b_re  = b_re;
        in_b_im  = b_im;
        in_mode  = mode;
        in_last  = last;
        in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("send_ready", 64'(in_ready), 64'(1));
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*DW:0] held;
        int            idx;
        logic          acc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in_last = 1'b0; in_mode = M_MUL;
        in_a_re = '0; in_a_im = '0; in_b_re = '0; in_b_im = '0;
        repeat (3) tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_re", 64'(out_re), 64'(0));
        check("rst_out_im", 64'(out_im), 64'(0));
        check("rst_out_sat", 64'(out_sat), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'(1));

        // Latency: accepted at edge k, visible after edge k+2
        in_a_re = 16'h4000; in_a_im = 16'h0000; in_b_re = 16'h4000; in_b_im = 16'h4000;
        in_mode = M_MUL; in_last = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("lat_k", 64'(out_valid), 64'(0));
        tick();
        check("lat_k1", 64'(out_valid), 64'(0));
        tick();
        check("lat_k2_valid", 64'(out_valid), 64'(1));
        check("lat_k2_data", 64'({out_sat, out_re, out_im}), 64'({1'b0, 16'h2000, 16'h2000}));
        tick();
        rx.delete();

        send(16'h0001, 16'h0000, 16'h4000, 16'h0000, M_MUL, 1'b0);
        repeat (4) tick();
        check("round_count", 64'(rx.size()), 64'(1));
        check_rx("round_half_up", 0, {1'b0, 16'h0001, 16'h0000});
        rx.delete();

        send(16'h0000, 16'h4000, 16'h0000, 16'h4000, M_CMUL, 1'b0);
        send(16'h0000, 16'h4000, 16'h0000, 16'h4000, M_MUL, 1'b0);
        repeat (4) tick();
        check("conj_count", 64'(rx.size()), 64'(2));
        check_rx("cmul", 0, {1'b0, 16'h2000, 16'h0000});
        check_rx("mul_neg", 1, {1'b0, 16'hE000, 16'h0000});
        rx.delete();

        send(16'h8000, 16'h8000, 16'h8000, 16'h8000, M_MUL, 1'b0);
        repeat (4) tick();
        check_rx("sat_im_clip", 0, {1'b1, 16'h0000, 16'h7FFF});
        rx.delete();

        // Three-term accumulation, then a single term proving the clear
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b0);
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b0);
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b1);
        repeat (5) tick();
        check("mac3_count", 64'(rx.size()), 64'(1));
        check_rx("mac3_sum", 0, {1'b0, 16'h6000, 16'h0000});
        rx.delete();
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b1);
        repeat (5) tick();
        check("mac1_count", 64'(rx.size()), 64'(1));
        check_rx("mac1_cleared", 0, {1'b0, 16'h2000, 16'h0000});
        rx.delete();

        // Streaming with downstream stalled for cycles 4..8
        idx = 0;
        held = '0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc < 9);
            if (idx < 8) begin
                in_a_re  = 16'h4000;
                in_a_im  = 16'h0000;
                in_b_re  = 16'(32'h200 * (idx + 1));
                in_b_im  = 16'(-(32'h100 * (idx + 1)));
                in_mode  = M_MUL;
                in_last  = 1'b0;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (cyc >= 4 && cyc < 9) begin
                check("stall_in_ready", 64'(in_ready), 64'(0));
                check("stall_out_valid", 64'(out_valid), 64'(1));
                if (cyc == 4) held = {out_sat, out_re, out_im};
                else check("stall_stable", 64'({out_sat, out_re, out_im}), 64'(held));
            end
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (acc) idx++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_count", 64'(rx.size()), 64'(8));
        for (int i = 0; i < 8; i++)
            check_rx("bp_order", i, {1'b0, 16'(32'h100 * (i + 1)), 16'(-(32'h80 * (i + 1)))});
        rx.delete();

        // Reset while two MAC terms are in flight
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b0);
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(16'h4000, 16'h0000, 16'h4000, 16'h0000, M_MAC, 1'b1);
        repeat (5) tick();
        check("rstmac_count", 64'(rx.size()), 64'(1));
        check_rx("rstmac_sum", 0, {1'b0, 16'h2000, 16'h0000});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
